// File: rtl/gray_step_decoder_if.sv
// Bundle of the sample-in / result-out signals of gray_step_decoder.
//   master : Gray source / result consumer (drives in_valid, gray_in, clear_err)
//   slave  : the decoder (drives out_valid, bin_out, step flags, err_cnt)
interface gray_step_decoder_if #(parameter int unsigned W = 3);
  logic         in_valid;
  logic [W-1:0] gray_in;
  logic         clear_err;
  logic         out_valid;
  logic [W-1:0] bin_out;
  logic         step_up;
  logic         step_dn;
  logic         wrap;
  logic         step_err;
  logic [7:0]   err_cnt;

  modport master (
    output in_valid, gray_in, clear_err,
    input  out_valid, bin_out, step_up, step_dn, wrap, step_err, err_cnt
  );

  modport slave (
    input  in_valid, gray_in, clear_err,
    output out_valid, bin_out, step_up, step_dn, wrap, step_err, err_cnt
  );
endinterface

// File: rtl/gray_step_decoder.sv
// Gray-code stream decoder with step classification.
// Stage 1 captures each valid Gray sample; stage 2 decodes it to binary and
// classifies it against the previously decoded sample as hold, up-step,
// down-step (with wrap across 2^W-1 <-> 0) or illegal jump.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave modport -- in_valid/gray_in/clear_err in;
//                out_valid/bin_out/step_up/step_dn/wrap/step_err/err_cnt out
// All outputs are registered; latency is two cycles from in_valid.
module gray_step_decoder #(
  parameter int unsigned W = 3
) (
  input logic                 clk,
  input logic                 rst_n,
  gray_step_decoder_if.slave  bus
);

  typedef enum logic {PRIME, TRACK} state_t;

  localparam logic [W-1:0] ONE = W'(1);

  state_t       state_q, state_d;
  logic         s1_valid;
  logic [W-1:0] s1_gray;
  logic [W-1:0] dec;
  logic [W-1:0] delta;
  logic [W-1:0] prev_q, prev_d;
  logic [W-1:0] bin_q, bin_d;
  logic         ov_q, ov_d;
  logic         up_q, up_d;
  logic         dn_q, dn_d;
  logic         wrap_q, wrap_d;
  logic         err_q, err_d;
  logic [7:0]   cnt_q, cnt_d;

  // Stage 1: sample register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_gray  <= '0;
    end else begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) s1_gray <= bus.gray_in;
    end
  end

  // Binary bit i is the XOR of all Gray bits at or above i.
  always_comb begin
    dec = '0;
    for (int unsigned i = 0; i < W; i++) dec[i] = ^(s1_gray >> i);
  end

  assign delta = dec - prev_q;

  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    bin_d   = bin_q;
    ov_d    = 1'b0;
    up_d    = 1'b0;
    dn_d    = 1'b0;
    wrap_d  = 1'b0;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    if (s1_valid) begin
      ov_d   = 1'b1;
      prev_d = dec;
      bin_d  = dec;
      unique case (state_q)
        PRIME: state_d = TRACK;
        TRACK: begin
          if (delta == '0) begin
            // hold
          end else if (delta == ONE) begin
            up_d   = 1'b1;
            wrap_d = (prev_q == '1);
          end else if (delta == '1) begin
            dn_d   = 1'b1;
            wrap_d = (prev_q == '0);
          end else begin
            err_d = 1'b1;
            if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
          end
        end
        default: state_d = PRIME;
      endcase
    end
    // Clear takes priority over a same-cycle error increment.
    if (bus.clear_err) cnt_d = '0;
  end

  // Stage 2: FSM, tracking state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PRIME;
      prev_q  <= '0;
      bin_q   <= '0;
      ov_q    <= 1'b0;
      up_q    <= 1'b0;
      dn_q    <= 1'b0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      bin_q   <= bin_d;
      ov_q    <= ov_d;
      up_q    <= up_d;
      dn_q    <= dn_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.out_valid = ov_q;
  assign bus.bin_out   = bin_q;
  assign bus.step_up   = up_q;
  assign bus.step_dn   = dn_q;
  assign bus.wrap      = wrap_q;
  assign bus.step_err  = err_q;
  assign bus.err_cnt   = cnt_q;

endmodule

// File: tb/tb_gray_step_decoder.sv
// Directed bench for gray_step_decoder: table-driven W=3 stream plus
// hand-written reset, saturation/clear and W=2 / W=8 sweep sequences.
module tb_gray_step_decoder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gray_step_decoder_if #(.W(3)) b3();
  gray_step_decoder_if #(.W(2)) b2();
  gray_step_decoder_if #(.W(8)) b8();

  gray_step_decoder #(.W(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(b3));
  gray_step_decoder #(.W(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));
  gray_step_decoder #(.W(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8));

  int n_cmp = 0;
  int n_fail = 0;

  // flags = {out_valid, step_up, step_dn, wrap, step_err}
  typedef struct {
    logic       vld;
    logic [2:0] gray;
    logic [2:0] bin;
    logic [4:0] flags;
    logic [7:0] cnt;
  } vec_t;

  localparam int N = 20;
  vec_t tbl [N];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [4:0] exp_flags(input int prev, input int b, input int m, input bit first);
    int d;
    logic up, dn, wr, er;
    if (first) return 5'b10000;
    d  = (b - prev + m) % m;
    up = (d == 1);
    dn = (d == m - 1);
    wr = (up && prev == m - 1) || (dn && prev == 0);
    er = !(d == 0 || up || dn);
    return {1'b1, up, dn, wr, er};
  endfunction

  function automatic logic [4:0] f3();
    return {b3.out_valid, b3.step_up, b3.step_dn, b3.wrap, b3.step_err};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int prev, b, m;
    bit first;

    tbl[0]  = '{1'b1, 3'b000, 3'd0, 5'b10000, 8'd0};
    tbl[1]  = '{1'b1, 3'b001, 3'd1, 5'b11000, 8'd0};
    tbl[2]  = '{1'b1, 3'b011, 3'd2, 5'b11000, 8'd0};
    tbl[3]  = '{1'b1, 3'b010, 3'd3, 5'b11000, 8'd0};
    tbl[4]  = '{1'b1, 3'b110, 3'd4, 5'b11000, 8'd0};
    tbl[5]  = '{1'b1, 3'b111, 3'd5, 5'b11000, 8'd0};
    tbl[6]  = '{1'b1, 3'b101, 3'd6, 5'b11000, 8'd0};
    tbl[7]  = '{1'b1, 3'b100, 3'd7, 5'b11000, 8'd0};
    tbl[8]  = '{1'b1, 3'b000, 3'd0, 5'b11010, 8'd0};
    tbl[9]  = '{1'b1, 3'b100, 3'd7, 5'b10110, 8'd0};
    tbl[10] = '{1'b0, 3'b000, 3'd7, 5'b00000, 8'd0};
    tbl[11] = '{1'b0, 3'b000, 3'd7, 5'b00000, 8'd0};
    tbl[12] = '{1'b0, 3'b000, 3'd7, 5'b00000, 8'd0};
    tbl[13] = '{1'b1, 3'b101, 3'd6, 5'b10100, 8'd0};
    tbl[14] = '{1'b1, 3'b000, 3'd0, 5'b10001, 8'd1};
    tbl[15] = '{1'b1, 3'b100, 3'd7, 5'b10110, 8'd1};
    tbl[16] = '{1'b1, 3'b010, 3'd3, 5'b10001, 8'd2};
    tbl[17] = '{1'b1, 3'b010, 3'd3, 5'b10000, 8'd2};
    tbl[18] = '{1'b1, 3'b001, 3'd1, 5'b10001, 8'd3};
    tbl[19] = '{1'b1, 3'b011, 3'd2, 5'b11000, 8'd3};

    b3.in_valid = 1'b0; b3.gray_in = '0; b3.clear_err = 1'b0;
    b2.in_valid = 1'b0; b2.gray_in = '0; b2.clear_err = 1'b0;
    b8.in_valid = 1'b0; b8.gray_in = '0; b8.clear_err = 1'b0;

    // Reset state
    tick(); tick();
    chk("reset_flags", 32'(f3()), 32'd0);
    chk("reset_bin", 32'(b3.bin_out), 32'd0);
    chk("reset_cnt", 32'(b3.err_cnt), 32'd0);
    rst_n = 1'b1;

    // Table: sweep up, down with gaps, hold and error
    for (int i = 0; i <= N; i++) begin
      if (i < N) begin
        b3.in_valid = tbl[i].vld;
        b3.gray_in  = tbl[i].gray;
      end else begin
        b3.in_valid = 1'b0;
      end
      tick();
      if (i >= 1) begin
        chk($sformatf("tbl%0d_flags", i - 1), 32'(f3()), 32'(tbl[i-1].flags));
        chk($sformatf("tbl%0d_bin", i - 1), 32'(b3.bin_out), 32'(tbl[i-1].bin));
        chk($sformatf("tbl%0d_cnt", i - 1), 32'(b3.err_cnt), 32'(tbl[i-1].cnt));
      end
    end

    // Mid-stream asynchronous reset
    b3.in_valid = 1'b1; b3.gray_in = 3'b110;
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_flags", 32'(f3()), 32'd0);
    chk("mid_rst_bin", 32'(b3.bin_out), 32'd0);
    chk("mid_rst_cnt", 32'(b3.err_cnt), 32'd0);
    b3.in_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    b3.in_valid = 1'b1; b3.gray_in = 3'b011;
    tick();
    b3.in_valid = 1'b0;
    tick();
    chk("prime_flags", 32'(f3()), 32'b10000);
    chk("prime_bin", 32'(b3.bin_out), 32'd2);
    tick();
    chk("prime_idle_flags", 32'(f3()), 32'd0);
    chk("prime_idle_bin", 32'(b3.bin_out), 32'd2);

    // Error counter saturation: every sample is an illegal jump
    for (int i = 0; i < 300; i++) begin
      b3.in_valid = 1'b1;
      b3.gray_in  = (i % 2 == 0) ? 3'b000 : 3'b010;
      tick();
    end
    b3.in_valid = 1'b0;
    tick(); tick();
    chk("sat_cnt", 32'(b3.err_cnt), 32'd255);

    // clear_err coinciding with an error result
    b3.in_valid = 1'b1; b3.gray_in = 3'b000; b3.clear_err = 1'b1;
    tick();
    b3.in_valid = 1'b0;
    tick();
    chk("clr_err_flags", 32'(f3()), 32'b10001);
    chk("clr_err_cnt", 32'(b3.err_cnt), 32'd0);
    b3.clear_err = 1'b0;
    tick();
    chk("clr_after_cnt", 32'(b3.err_cnt), 32'd0);

    // W=2 full up then down cycle
    m = 4; first = 1'b1; prev = 0;
    for (int k = 0; k <= 2 * m; k++) begin
      b = (k <= m) ? (k % m) : (2 * m - k);
      b2.in_valid = 1'b1;
      b2.gray_in  = 2'(b ^ (b >> 1));
      tick();
      b2.in_valid = 1'b0;
      tick();
      chk($sformatf("w2_s%0d_bin", k), 32'(b2.bin_out), 32'(b));
      chk($sformatf("w2_s%0d_flags", k),
          32'({b2.out_valid, b2.step_up, b2.step_dn, b2.wrap, b2.step_err}),
          32'(exp_flags(prev, b, m, first)));
      prev = b; first = 1'b0;
    end
    chk("w2_cnt", 32'(b2.err_cnt), 32'd0);

    // W=8 full up then down cycle
    m = 256; first = 1'b1; prev = 0;
    for (int k = 0; k <= 2 * m; k++) begin
      b = (k <= m) ? (k % m) : (2 * m - k);
      b8.in_valid = 1'b1;
      b8.gray_in  = 8'(b ^ (b >> 1));
      tick();
      b8.in_valid = 1'b0;
      tick();
      chk($sformatf("w8_s%0d_bin", k), 32'(b8.bin_out), 32'(b));
      chk($sformatf("w8_s%0d_flags", k),
          32'({b8.out_valid, b8.step_up, b8.step_dn, b8.wrap, b8.step_err}),
          32'(exp_flags(prev, b, m, first)));
      prev = b; first = 1'b0;
    end
    chk("w8_cnt", 32'(b8.err_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/gray_step_decoder.md
# gray_step_decoder

Receive-side companion to the 3-bit binary-to-Gray encoder: accepts a stream of Gray-coded samples, such as a Gray counter or position code crossing from another block, and decodes each to binary in a 2-stage pipeline. Every accepted sample is checked against the previous one and classified as hold, up-step, down-step or illegal jump. Reports wrap-around events and keeps a saturating error count. Sits between the Gray source and any binary consumer (counters, comparators, displays).

## Interface
- W, default 3: code width in bits; legal range 2..16.
- clk, input, 1: single clock; all state updates on its rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- in_valid, input, 1: gray_in carries a sample this cycle.
- gray_in, input, W: Gray-coded sample, MSB first.
- clear_err, input, 1: synchronous clear of err_cnt.
- out_valid, output, 1: one-cycle pulse; the result fields below are valid.
- bin_out, output, W: decoded binary value of the sample.
- step_up, output, 1: sample is previous + 1 (mod 2^W).
- step_dn, output, 1: sample is previous − 1 (mod 2^W).
- wrap, output, 1: step crossed the 2^W−1 ↔ 0 boundary.
- step_err, output, 1: sample differs from previous by anything other than 0 or ±1.
- err_cnt, output, 8: count of step_err events, saturating at 255.

## Operation
- Decode: bin[W-1] = gray[W-1]; bin[i] = bin[i+1] ^ gray[i] for i = W-2 down to 0.
- Stage 1: when in_valid = 1, register gray_in and set s1_valid. When in_valid = 0, clear s1_valid.
- Stage 2: when s1_valid = 1, decode the registered sample, then compare it with prev (the last decoded value) using delta = (new − prev) mod 2^W.
- FSM has two states, PRIME and TRACK. Reset state is PRIME.
  - PRIME: first valid sample sets prev and asserts out_valid with bin_out. No step_up, step_dn, wrap or step_err. Move to TRACK.
  - TRACK, delta 0: hold. out_valid only.
  - TRACK, delta 1: step_up. Also wrap if prev = 2^W−1.
  - TRACK, delta 2^W−1: step_dn. Also wrap if prev = 0.
  - TRACK, any other delta: step_err, and err_cnt += 1 unless it is already 255.
- prev and bin_out always take the new decoded value, including on error (resync to the new value). The FSM stays in TRACK.
- step_up, step_dn and step_err are mutually exclusive. wrap asserts only together with step_up or step_dn.
- clear_err: err_cnt becomes 0 on the next edge. If an error occurs in the same cycle, clear wins and err_cnt = 0.
- Reset, asynchronous, including mid-stream:
  - Pipeline is flushed and the FSM returns to PRIME.
  - prev = 0, bin_out = 0, err_cnt = 0.
  - out_valid, step_up, step_dn, wrap and step_err are all 0.

## Timing
- Latency: a sample with in_valid high in cycle n yields out_valid high in cycle n+2. All outputs are registered.
- Throughput: one sample per cycle, back-to-back, with no stall and no backpressure.
- Pulse outputs (out_valid, step_up, step_dn, wrap, step_err) are high for exactly one cycle per sample. They are 0 in cycles without a result.
- bin_out holds its last value while out_valid = 0. err_cnt is a level output.
- Gaps in in_valid do not disturb prev. Comparison is always against the last valid sample.
- rst_n deassertion: the first in_valid is sampled at the first rising edge after release.

## Test plan
- Reset: assert rst_n = 0 mid-stream → all outputs 0 immediately. After release, the next sample gray 011 gives bin_out = 2 with no step flags (PRIME).
- Count-up sweep (W=3): gray 000, 001, 011, 010, 110, 111, 101, 100, 000 back-to-back → bin_out 0,1,2,3,4,5,6,7,0 each 2 cycles after input. step_up on all but the first. wrap only on 7→0.
- Count-down with gaps: gray 100 (7), idle 3 cycles, 101 (6), 000 (0), 100 (7) → step_dn on 7→6. 6→0 gives step_err and err_cnt = 1. 0→7 gives step_dn with wrap.
- Hold and error: gray 010 twice, then 001 → second sample gives out_valid only. 3→1 gives step_err, bin_out = 1, then tracking continues from 1.
- Error counter: 300 alternating 000/010 samples → err_cnt saturates at 255. Pulsing clear_err while an error arrives in the same cycle → err_cnt = 0.
- Parameter sweep: W=2 and W=8 full up and down cycles → correct decode; wrap only at 2^W−1 ↔ 0; no step_err.
